// File: rtl/pipe_ctrl_regs.sv
// rtl/pipe_ctrl_regs.sv - ID/EX, EX/MEM and MEM/WB control and destination pipeline registers
//
// Purpose: carries decoded control bits and the destination register number
// from ID through EX, MEM and WB. The EX and MEM copies double as the hazard
// status the ID-stage controller reads for forwarding and load-use stalls.
// A stall request or an empty ID stage turns the EX capture into a bubble;
// the MEM and WB stages always advance.
//
// Optional feature: macro PIPE_PERF_CNT_EN enables the saturating 16-bit
// stall and retired-instruction counters. When the macro is undefined,
// STALLCNT and RETCNT are tied to 0.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   IDVALID, WPCIR                 ID holds an instruction / stall request
//   WREG M2REG WMEM SHIFT ALUIMM   ID-stage control bits
//   REGRT ALUC IDRT IDRD           destination select, ALU op, rt, rd
//   EVALID .. EXDES                EX-stage control and destination
//   MVALID .. MEDES                MEM-stage control and destination
//   WVALID .. WBDES                WB-stage control and destination
//   STALLCNT, RETCNT               performance counters

module pipe_ctrl_regs (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IDVALID,
  input  logic        WPCIR,
  input  logic        WREG,
  input  logic        M2REG,
  input  logic        WMEM,
  input  logic        SHIFT,
  input  logic        ALUIMM,
  input  logic        REGRT,
  input  logic [3:0]  ALUC,
  input  logic [4:0]  IDRT,
  input  logic [4:0]  IDRD,
  output logic        EVALID,
  output logic        EWREG,
  output logic        EM2REG,
  output logic        EWMEM,
  output logic        ESHIFT,
  output logic        EALUIMM,
  output logic [3:0]  EALUC,
  output logic [4:0]  EXDES,
  output logic        MVALID,
  output logic        MWREG,
  output logic        MM2REG,
  output logic        MWMEM,
  output logic [4:0]  MEDES,
  output logic        WVALID,
  output logic        WWREG,
  output logic        WM2REG,
  output logic [4:0]  WBDES,
  output logic [15:0] STALLCNT,
  output logic [15:0] RETCNT
);

  logic       capture;
  logic [4:0] id_des;
  logic       id_wreg;
  logic       id_m2reg;

  assign capture = IDVALID && !WPCIR;
  assign id_des  = REGRT ? IDRT : IDRD;
  // A write to $0 is dropped at capture, so no later stage ever reports it
  // as a hazard. A load only counts as a load if it really writes a register.
  assign id_wreg  = WREG && (id_des != 5'd0);
  assign id_m2reg = M2REG && id_wreg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      EVALID  <= 1'b0;
      EWREG   <= 1'b0;
      EM2REG  <= 1'b0;
      EWMEM   <= 1'b0;
      ESHIFT  <= 1'b0;
      EALUIMM <= 1'b0;
      EALUC   <= 4'd0;
      EXDES   <= 5'd0;
      MVALID  <= 1'b0;
      MWREG   <= 1'b0;
      MM2REG  <= 1'b0;
      MWMEM   <= 1'b0;
      MEDES   <= 5'd0;
      WVALID  <= 1'b0;
      WWREG   <= 1'b0;
      WM2REG  <= 1'b0;
      WBDES   <= 5'd0;
    end else begin
      if (capture) begin
        EVALID  <= 1'b1;
        EWREG   <= id_wreg;
        EM2REG  <= id_m2reg;
        EWMEM   <= WMEM;
        ESHIFT  <= SHIFT;
        EALUIMM <= ALUIMM;
        EALUC   <= ALUC;
        EXDES   <= id_des;
      end else begin
        // Bubble: fully zeroed so it can never write memory or registers.
        EVALID  <= 1'b0;
        EWREG   <= 1'b0;
        EM2REG  <= 1'b0;
        EWMEM   <= 1'b0;
        ESHIFT  <= 1'b0;
        EALUIMM <= 1'b0;
        EALUC   <= 4'd0;
        EXDES   <= 5'd0;
      end

      // Downstream stages never freeze; a stall only affects EX capture.
      MVALID <= EVALID;
      MWREG  <= EWREG;
      MM2REG <= EM2REG;
      MWMEM  <= EWMEM;
      MEDES  <= EXDES;

      WVALID <= MVALID;
      WWREG  <= MWREG;
      WM2REG <= MM2REG;
      WBDES  <= MEDES;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALLCNT <= 16'd0;
      RETCNT   <= 16'd0;
    end else begin
      if (WPCIR && (STALLCNT != 16'hffff)) begin
        STALLCNT <= STALLCNT + 16'd1;
      end
      if (WVALID && (RETCNT != 16'hffff)) begin
        RETCNT <= RETCNT + 16'd1;
      end
    end
  end
`else
  assign STALLCNT = 16'd0;
  assign RETCNT   = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// tb/tb_pipe_ctrl_regs.sv - directed self-checking bench for pipe_ctrl_regs

module tb_pipe_ctrl_regs;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IDVALID, WPCIR;
  logic        WREG, M2REG, WMEM, SHIFT, ALUIMM, REGRT;
  logic [3:0]  ALUC;
  logic [4:0]  IDRT, IDRD;
  logic        EVALID, EWREG, EM2REG, EWMEM, ESHIFT, EALUIMM;
  logic [3:0]  EALUC;
  logic [4:0]  EXDES;
  logic        MVALID, MWREG, MM2REG, MWMEM;
  logic [4:0]  MEDES;
  logic        WVALID, WWREG, WM2REG;
  logic [4:0]  WBDES;
  logic [15:0] STALLCNT, RETCNT;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl_regs dut (
    .CLK(CLK), .RST(RST), .IDVALID(IDVALID), .WPCIR(WPCIR),
    .WREG(WREG), .M2REG(M2REG), .WMEM(WMEM), .SHIFT(SHIFT),
    .ALUIMM(ALUIMM), .REGRT(REGRT), .ALUC(ALUC), .IDRT(IDRT), .IDRD(IDRD),
    .EVALID(EVALID), .EWREG(EWREG), .EM2REG(EM2REG), .EWMEM(EWMEM),
    .ESHIFT(ESHIFT), .EALUIMM(EALUIMM), .EALUC(EALUC), .EXDES(EXDES),
    .MVALID(MVALID), .MWREG(MWREG), .MM2REG(MM2REG), .MWMEM(MWMEM),
    .MEDES(MEDES), .WVALID(WVALID), .WWREG(WWREG), .WM2REG(WM2REG),
    .WBDES(WBDES), .STALLCNT(STALLCNT), .RETCNT(RETCNT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IDVALID = 0; WPCIR = 0; WREG = 0; M2REG = 0; WMEM = 0; SHIFT = 0;
    ALUIMM = 0; REGRT = 0; ALUC = 4'd0; IDRT = 5'd0; IDRD = 5'd0;
  endtask

  task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                       input logic regrt, input logic aluimm, input logic [3:0] aluc,
                       input logic [4:0] rt, input logic [4:0] rd);
    idle();
    IDVALID = 1; WREG = wreg; M2REG = m2reg; WMEM = wmem; REGRT = regrt;
    ALUIMM = aluimm; ALUC = aluc; IDRT = rt; IDRD = rd;
  endtask

  function automatic logic [31:0] all_outputs();
    return {EVALID, EWREG, EM2REG, EWMEM, ESHIFT, EALUIMM, EALUC, EXDES,
            MVALID, MWREG, MM2REG, MWMEM, MEDES, WVALID, WWREG, WM2REG} | {WBDES, 27'd0};
  endfunction

  initial begin
    idle();
    RST = 1;
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      IDVALID = 1'($urandom); WPCIR = 1'($urandom); WREG = 1'($urandom);
      M2REG = 1'($urandom); WMEM = 1'($urandom); SHIFT = 1'($urandom);
      ALUIMM = 1'($urandom); REGRT = 1'($urandom); ALUC = 4'($urandom);
      IDRT = 5'($urandom); IDRD = 5'($urandom);
      step();
    end
    check("reset_outputs", all_outputs(), 32'd0);
    check("reset_stallcnt", {16'd0, STALLCNT}, 32'd0);
    check("reset_retcnt", {16'd0, RETCNT}, 32'd0);
    RST = 0;

    // Straight-line add $3.
    issue(1, 0, 0, 0, 0, 4'b0010, 5'd7, 5'd3);
    step();
    check("add_e", {EVALID, EWREG, EM2REG, EWMEM, EALUC, 3'd0, EXDES},
          {1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 3'd0, 5'd3});
    idle();
    step();
    check("add_m", {MVALID, MWREG, MM2REG, MWMEM, 3'd0, MEDES}, {4'b1100, 3'd0, 5'd3});
    check("add_bubble_behind", {EVALID, EWREG, EXDES}, 32'd0);
    step();
    check("add_w", {WVALID, WWREG, WM2REG, 3'd0, WBDES}, {3'b110, 3'd0, 5'd3});

    // Load-use: lw $5, then a dependent add $6 stalled for one cycle.
    issue(1, 1, 0, 1, 1, 4'b0000, 5'd5, 5'd9);
    step();
    check("lw_e", {EVALID, EWREG, EM2REG, 3'd0, EXDES}, {3'b111, 3'd0, 5'd5});
    issue(1, 0, 0, 0, 0, 4'b0010, 5'd5, 5'd6);
    WPCIR = 1;
    step();
    check("lu_stall_e", {EVALID, EWREG, EM2REG, EXDES}, 32'd0);
    check("lu_stall_m", {MM2REG, MWREG, 3'd0, MEDES}, {2'b11, 3'd0, 5'd5});
    WPCIR = 0;
    step();
    check("lu_release_e", {EVALID, EWREG, 3'd0, EXDES}, {2'b11, 3'd0, 5'd6});
    check("lu_bubble_m", {MVALID, MWREG, MEDES}, 32'd0);
    check("lu_load_w", {WVALID, WM2REG, 3'd0, WBDES}, {2'b11, 3'd0, 5'd5});

    // addi $0: write dropped everywhere.
    issue(1, 0, 0, 1, 1, 4'b0010, 5'd0, 5'd12);
    step();
    check("zero_e", {EVALID, EWREG, EALUIMM, 3'd0, EXDES}, {3'b101, 3'd0, 5'd0});
    idle();
    step();
    check("zero_m", {MVALID, MWREG}, {2'b10});
    step();
    check("zero_w", {WVALID, WWREG}, {2'b10});

    // Load into $0 must not look like a load either.
    issue(1, 1, 0, 1, 0, 4'd0, 5'd0, 5'd0);
    step();
    check("lw_zero_e", {EVALID, EWREG, EM2REG}, {3'b100});

    // Store, then the same store under stall.
    issue(0, 0, 1, 1, 1, 4'b0010, 5'd4, 5'd0);
    step();
    check("sw_e", {EVALID, EWREG, EWMEM}, {3'b101});
    WPCIR = 1;
    step();
    check("sw_stall_e", {EVALID, EWMEM}, 32'd0);
    check("sw_m", {MVALID, MWMEM, MWREG}, {3'b110});

    // Back-to-back stall: second stall cycle is also a bubble.
    step();
    check("stall2_e", {EVALID, EWMEM}, 32'd0);
    check("stall2_m", {MVALID, MWMEM}, 32'd0);
    WPCIR = 0;

    // Shift op latency and reset mid-stream.
    issue(1, 0, 0, 0, 0, 4'b0011, 5'd1, 5'd17);
    SHIFT = 1;
    step();
    check("sll_e", {ESHIFT, EALUC, 3'd0, EXDES}, {1'b1, 4'b0011, 3'd0, 5'd17});
    step();
    RST = 1;
    step();
    check("midreset_outputs", all_outputs(), 32'd0);
    RST = 0;
    idle();

`ifdef PIPE_PERF_CNT_EN
    // Three retiring instructions; edges after this reset are counted.
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 0, 0, 4'd0, 5'd0, 5'(i + 1));
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();
    check("retcnt_3", {16'd0, RETCNT}, 32'd3);
    check("stallcnt_0", {16'd0, STALLCNT}, 32'd0);
    WPCIR = 1;
    for (int i = 0; i < 65540; i++) step();
    check("stallcnt_sat", {16'd0, STALLCNT}, 32'h0000ffff);
    step();
    check("stallcnt_held", {16'd0, STALLCNT}, 32'h0000ffff);
    WPCIR = 0;
`else
    // Counters compiled out: stay 0 despite stalls and retirements.
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 0, 0, 4'd0, 5'd0, 5'(i + 1));
      step();
    end
    WPCIR = 1;
    for (int i = 0; i < 6; i++) step();
    check("retcnt_off", {16'd0, RETCNT}, 32'd0);
    check("stallcnt_off", {16'd0, STALLCNT}, 32'd0);
    WPCIR = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
